// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default widths for the data-memory responder.
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
   localparam int DMEM_ARQ = 16;
   localparam int DMEM_ADDR_SIZE = 13;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x ARQ storage, synchronous write, combinational read.
module dmem_array #(
   parameter int ARQ = 16,
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  addr,
   input  logic [ARQ-1:0] wdata,
   output logic [ARQ-1:0] rdata
);
   logic [ARQ-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state memory responder for the MEM stage; latches one request,
// counts down WAIT_CYCLES, then completes it in a single ack cycle.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ARQ = DMEM_ARQ,
   parameter int MEMORY_ADDR_SIZE = DMEM_ADDR_SIZE,
   parameter int DEPTH = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rd_en,
   input  logic                        wr_en,
   input  logic [MEMORY_ADDR_SIZE-1:0] addr,
   input  logic [ARQ-1:0]              wr_data,
   output logic [ARQ-1:0]              rd_data,
   output logic                        ack,
   output logic                        err,
   output logic                        stall
);
   localparam int AW = $clog2(DEPTH);
   state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [MEMORY_ADDR_SIZE-1:0] addr_q, addr_d;
   logic [ARQ-1:0] data_q, data_d, rd_data_q, rd_data_d, arr_rdata;
   logic rd_q, rd_d, wr_q, wr_d;
   logic req, oor, coll, mem_we;
   assign req = rd_en | wr_en;
   assign oor = |(addr_q >> AW);
   assign coll = rd_q & wr_q;
   // Reset in the RESP cycle must not let the write land.
   assign mem_we = (state_q == RESP) & wr_q & ~coll & ~oor & ~rst;
   assign ack = state_q == RESP;
   assign err = ack & (coll | oor);
   assign stall = (state_q == WAIT) | ((state_q == IDLE) & req);
   assign rd_data = rd_data_q;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      addr_d = addr_q;
      data_d = data_q;
      rd_d = rd_q;
      wr_d = wr_q;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: if (req) begin
            addr_d = addr;
            data_d = wr_data;
            rd_d = rd_en;
            wr_d = wr_en;
            cnt_d = 4'(WAIT_CYCLES);
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
         end
         default: begin
            state_d = IDLE;
            cnt_d = '0;
            if (rd_q & ~coll) rd_data_d = oor ? '0 : arr_rdata;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         rd_data_q <= '0;
         addr_q <= '0;
         data_q <= '0;
         rd_q <= 1'b0;
         wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rd_data_q <= rd_data_d;
         addr_q <= addr_d;
         data_q <= data_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
      end
   end
   dmem_array #(.ARQ(ARQ), .DEPTH(DEPTH)) u_array (
      .clk(clk),
      .we(mem_we),
      .addr(addr_q[AW-1:0]),
      .wdata(data_q),
      .rdata(arr_rdata)
   );
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ARQ, default 16, meaning data word width.
REQ-002 The block SHALL have parameter MEMORY_ADDR_SIZE, default 13, meaning request address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning implemented word count, a power of two not above 2**MEMORY_ADDR_SIZE.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response, range 0..15.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port rd_en, input, 1 bit, meaning read request from the MEM stage.
REQ-008 The block SHALL have port wr_en, input, 1 bit, meaning write request from the MEM stage.
REQ-009 The block SHALL have port addr, input, MEMORY_ADDR_SIZE bits, meaning word address.
REQ-010 The block SHALL have port wr_data, input, ARQ bits, meaning write data.
REQ-011 The block SHALL have port rd_data, output, ARQ bits, meaning registered read data.
REQ-012 The block SHALL have port ack, output, 1 bit, meaning one-cycle completion strobe.
REQ-013 The block SHALL have port err, output, 1 bit, meaning error qualifier, valid only with ack.
REQ-014 The block SHALL have port stall, output, 1 bit, meaning pipeline freeze request.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 In IDLE, rd_en or wr_en high SHALL latch addr, wr_data and the op, then move to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles via a down-counter loaded at acceptance, then move to RESP.
REQ-018 RESP SHALL last one cycle with ack=1, perform the latched op, and return to IDLE.
REQ-019 Latency: a request accepted at cycle T SHALL produce ack in cycle T+1+WAIT_CYCLES.
REQ-020 A read SHALL update rd_data in RESP, and rd_data SHALL hold until the next successful read completes.
REQ-021 A write SHALL update the array only in the RESP cycle; rd_data SHALL be unchanged by writes.
REQ-022 stall SHALL be combinational: high in IDLE when a request is present, high in WAIT, and low in RESP and in idle-no-request cycles.
REQ-023 Inputs SHALL be sampled only in IDLE; changes during WAIT or RESP SHALL be ignored.
REQ-024 A request still asserted in the IDLE cycle after ack SHALL be treated as a new request.
REQ-025 rd_en and wr_en high together SHALL complete with ack=1, err=1, no array write, and rd_data unchanged.
REQ-026 addr >= DEPTH SHALL complete with ack=1, err=1, no array write, and rd_data forced to 0 for reads.
REQ-027 err SHALL be 0 on every cycle where ack=0.
REQ-028 Back-to-back requests SHALL sustain one completion per 2+WAIT_CYCLES cycles.

Reset
REQ-029 rst high at a clock edge SHALL force state to IDLE, counter to 0, rd_data to 0, ack to 0 and err to 0.
REQ-030 Array contents SHALL NOT be affected by rst.
REQ-031 rst asserted during WAIT SHALL abort the request with no write and no ack.
REQ-032 rst asserted in the same cycle as RESP SHALL suppress the write.

Structure
REQ-033 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the ARQ and MEMORY_ADDR_SIZE default constants.
REQ-034 The storage SHALL be a sub-module dmem_array: single port, synchronous write, combinational read, DEPTH x ARQ.
REQ-035 The FSM, counter, request latch and error decode SHALL reside in dmem_responder.

Verification
REQ-036 Write then read, WAIT_CYCLES=2: wr addr 0x010 data 0xBEEF, then rd 0x010 -> each ack 3 cycles after acceptance, rd_data=0xBEEF, err=0.
REQ-037 WAIT_CYCLES=0, rd held high for 4 consecutive reads -> ack every second cycle, stall high only on acceptance cycles.
REQ-038 Out of range, DEPTH=256: wr 0x100 data 0x1234, then rd 0x100 -> both err=1, rd 0x100 returns 0, array word 0x000 unchanged.
REQ-039 Collision: rd_en=wr_en=1 at addr 0x005 -> ack with err=1, word 0x005 keeps its prior value, rd_data unchanged.
REQ-040 Reset mid-op: wr 0x020 data 0xAAAA, rst in the first WAIT cycle -> no ack, state IDLE, later rd 0x020 returns the old value.
REQ-041 Input glitch: change addr and wr_data during WAIT -> the originally latched address and data are used.
